// File: rtl/issue_sequencer_pkg.sv
// issue_sequencer_pkg: shared types/constants for the qisp issue sequencer (ISSUE_QUEUE_CHECK_EN adds the FAULT state)
package issue_sequencer_pkg;
    localparam int PC_W_DEF = 16;
    localparam int QP_W_DEF = 4;
    localparam logic OP_ALU = 1'b0;
    localparam logic OP_MEM = 1'b1;
`ifdef ISSUE_QUEUE_CHECK_EN
    typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT, ST_FAULT} state_e;
`else
    typedef enum logic [2:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_e;
`endif
endpackage

// File: rtl/issue_sequencer_if.sv
// issue_sequencer_if: instruction- and data-memory handshake bundle between sequencer (master) and memories (slave)
interface issue_sequencer_if #(parameter int PC_W = 16) ();
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [15:0]     imem_data;
    logic            dmem_req;
    logic            dmem_ack;
    modport master (output imem_req, imem_addr, dmem_req, input imem_ack, imem_data, dmem_ack);
    modport slave  (input imem_req, imem_addr, dmem_req, output imem_ack, imem_data, dmem_ack);
endinterface

// File: rtl/issue_sequencer_queue_ptr_unit.sv
// issue_sequencer_queue_ptr_unit: register-queue head/tail/count, advanced once per retiring instruction
module issue_sequencer_queue_ptr_unit
    import issue_sequencer_pkg::*;
#(
    parameter int QP_W = QP_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_adv,
    input  logic            i_pop,
    input  logic            i_push,
    output logic [QP_W-1:0] o_head,
    output logic [QP_W-1:0] o_tail,
    output logic            o_empty,
    output logic            o_full
);
    logic [QP_W-1:0] r_head, r_tail;
    logic [QP_W:0]   r_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_adv) begin
            r_head  <= r_head + QP_W'(i_pop);
            r_tail  <= r_tail + QP_W'(i_push);
            r_count <= r_count + (QP_W+1)'(i_push) - (QP_W+1)'(i_pop);
        end
    end
    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_empty = r_count == '0;
    assign o_full  = r_count == {1'b1, {QP_W{1'b0}}};
endmodule

// File: rtl/issue_sequencer.sv
// issue_sequencer: fetch/exec/mem/halt sequencer owning pc, instruction register and queue pointers
// ISSUE_QUEUE_CHECK_EN enables queue overflow/underflow detection and the FAULT state
module issue_sequencer
    import issue_sequencer_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int QP_W = QP_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_sequencer_if.master   bus,
    output logic [15:0]         o_i_reg,
    input  logic                i_is_stop,
    input  logic                i_op_type,
    input  logic                i_rb_is_front,
    input  logic                i_rd_is_front,
    input  logic                i_jump_taken,
    input  logic [PC_W-1:0]     i_jump_target,
    output logic                o_wb_en,
    output logic [QP_W-1:0]     o_q_rd_addr,
    output logic [QP_W-1:0]     o_q_wr_addr,
    output logic [PC_W-1:0]     o_pc,
    output logic                o_halted,
    output logic                o_fault
);
    state_e          r_state;
    logic            r_imem_req, r_dmem_req, r_halted;
    logic [15:0]     r_i_reg;
    logic [PC_W-1:0] r_pc;
    logic            w_empty, w_full, w_qerr, w_exec_ok, w_retire;

    issue_sequencer_queue_ptr_unit #(.QP_W(QP_W)) u_qp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_adv   (w_retire),
        .i_pop   (i_rb_is_front),
        .i_push  (i_rd_is_front),
        .o_head  (o_q_rd_addr),
        .o_tail  (o_q_wr_addr),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

`ifdef ISSUE_QUEUE_CHECK_EN
    logic r_fault;
    // a balanced pop+push never changes the count, so it is legal even when empty or full
    assign w_qerr  = (i_rb_is_front && !i_rd_is_front && w_empty) || (i_rd_is_front && !i_rb_is_front && w_full);
    assign o_fault = r_fault;
`else
    logic w_unused;
    assign w_unused = w_empty ^ w_full;
    assign w_qerr   = 1'b0;
    assign o_fault  = 1'b0;
`endif

    assign w_exec_ok = r_state == ST_EXEC && !i_is_stop && !w_qerr;
    assign w_retire  = (w_exec_ok && i_op_type == OP_ALU) || (r_state == ST_MEM && bus.dmem_ack);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_i_reg    <= '0;
            r_pc       <= '0;
            r_halted   <= 1'b0;
`ifdef ISSUE_QUEUE_CHECK_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            if (w_retire)
                r_pc <= i_jump_taken ? i_jump_target : r_pc + PC_W'(1);
            case (r_state)
                ST_FETCH:
                    if (r_imem_req && bus.imem_ack) begin
                        r_i_reg    <= bus.imem_data;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_EXEC;
                    end else begin
                        r_imem_req <= 1'b1;
                    end
                ST_EXEC:
                    if (i_is_stop) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
`ifdef ISSUE_QUEUE_CHECK_EN
                    else if (w_qerr) begin
                        r_state <= ST_FAULT;
                        r_fault <= 1'b1;
                    end
`endif
                    else if (i_op_type == OP_MEM) begin
                        r_state    <= ST_MEM;
                        r_dmem_req <= 1'b1;
                    end else begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                ST_MEM:
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                default: ;
            endcase
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.dmem_req  = r_dmem_req;
    assign o_i_reg       = r_i_reg;
    assign o_pc          = r_pc;
    assign o_wb_en       = w_retire;
    assign o_halted      = r_halted;
endmodule
